// File: rtl/fifo_loader_pkg.sv
// loader_pkg: sizes, FSM state encoding and the row queue entry type shared by
// the fifo_loader top, its row queue and the interface.
package loader_pkg;

    localparam int NUM_ROWS   = 8;
    localparam int NUM_COLS   = 8;
    localparam int DATA_W     = 8;
    localparam int ROW_W      = 64;
    localparam int IDX_W      = 4;
    localparam int B_ROW_IDX  = 8;
    localparam int TOTAL_ROWS = NUM_ROWS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [ROW_W-1:0] data;
    } row_entry_t;

    // Column 0 sits in the top byte of a row, column 7 in the bottom byte.
    function automatic logic [DATA_W-1:0] rowByte(input logic [ROW_W-1:0] data,
                                                  input logic [2:0]       col);
        logic [5:0] lsb;
        lsb = {~col, 3'b000};
        return data[lsb +: DATA_W];
    endfunction

endpackage

// File: rtl/fifo_loader_if.sv
// fifo_loader_if: row fetcher handshake, FIFO write/read strobes, MAC control
// and phase status of the loader. The loader uses the slave view, the
// surrounding system (or a bench) the master view.
interface fifo_loader_if;
    import loader_pkg::*;

    logic [ROW_W-1:0]    row_data;
    logic [IDX_W-1:0]    row_idx;
    logic                row_valid;
    logic                row_ready;

    logic [NUM_ROWS-1:0] a_wr_en;
    logic                b_wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_ROWS-1:0] a_full;
    logic                b_full;
    logic [NUM_ROWS-1:0] a_empty;
    logic                b_empty;
    logic [NUM_ROWS-1:0] a_rd_en;
    logic                b_rd_en;

    logic                mac_clr;
    logic                mac_en;
    logic                load_done;
    logic                done;
    logic                restart;
    logic                overflow;

    modport slave (
        input  row_data, row_idx, row_valid,
        input  a_full, b_full, a_empty, b_empty, restart,
        output row_ready, a_wr_en, b_wr_en, wr_data, a_rd_en, b_rd_en,
        output mac_clr, mac_en, load_done, done, overflow
    );

    modport master (
        output row_data, row_idx, row_valid,
        output a_full, b_full, a_empty, b_empty, restart,
        input  row_ready, a_wr_en, b_wr_en, wr_data, a_rd_en, b_rd_en,
        input  mac_clr, mac_en, load_done, done, overflow
    );

endinterface

// File: rtl/fifo_loader_row_queue.sv
// row_queue: two-entry queue of {row_idx, row_data}. The head comes straight
// out of a storage register, so a row pushed into an empty queue is visible
// at the head on the following cycle. flush_i empties the queue and wins over
// a same-cycle push or pop.
module row_queue
    import loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  row_entry_t push_entry_i,
    input  logic       pop_i,
    output row_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    row_entry_t mem_q [2];
    logic       wrPtr_q;
    logic       rdPtr_q;
    logic [1:0] count_q;
    logic       doPush;
    logic       doPop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign doPush  = push_i && !full_o && !flush_i;
    assign doPop   = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rdPtr_q];

    // Entry storage: an accepted row lands in the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (doPush) begin
            mem_q[wrPtr_q] <= push_entry_i;
        end
    end

    // Pointers and occupancy; a push and a pop together leave the count alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else if (flush_i) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (doPush) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fifo_loader.sv
// fifo_loader: takes rows from the memory row fetcher, buffers them in a
// two-entry queue and serializes each row byte-by-byte into its A FIFO (rows
// 0..7) or the B FIFO (row 8). With all nine rows loaded it pops every FIFO in
// lockstep NUM_COLS times and drives the MAC clear/enable strobes.
// Build macro LOADER_ORDER_CHECK_EN: rows must arrive as 0..8 in sequence;
// an out-of-order row is dropped and latches order_err_o.
module fifo_loader
    import loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fifo_loader_if.slave bus
`ifdef LOADER_ORDER_CHECK_EN
    ,
    output logic         order_err_o
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic       enteredState_q;

    logic [2:0] byteCnt_q;
    logic [3:0] rowsLoaded_q;
    logic [2:0] popCnt_q;
    logic       macEn_q;
    logic       lastMac_q;
    logic       overflow_q;

    row_entry_t qHead;
    row_entry_t qPushEntry;
    logic       qFull;
    logic       qEmpty;
    logic       qPush;
    logic       qPop;
    logic       qFlush;

    logic       orderOk;
    logic       rowAccept;
    logic       headIsB;
    logic       targetFull;
    logic       writeFire;
    logic       lastByte;
    logic       popFire;

`ifdef LOADER_ORDER_CHECK_EN
    logic [IDX_W-1:0] expIdx_q;
    logic             orderErr_q;

    assign orderOk     = (bus.row_idx == expIdx_q);
    assign order_err_o = orderErr_q;
`else
    assign orderOk = 1'b1;
`endif

    // Rows are taken whenever the queue has room, whatever the phase; a
    // restart out of DONE throws away anything queued during compute.
    assign rowAccept  = bus.row_valid && !qFull && orderOk;
    assign qFlush     = (state_q == S_DONE) && bus.restart;
    assign qPush      = rowAccept;
    assign qPushEntry = '{idx: bus.row_idx, data: bus.row_data};

    // Any index past the last A row is routed to the B FIFO.
    assign headIsB    = (qHead.idx >= IDX_W'(B_ROW_IDX));
    assign targetFull = headIsB ? bus.b_full : bus.a_full[qHead.idx[2:0]];
    assign writeFire  = (state_q == S_LOAD) && !qEmpty && !targetFull;
    assign lastByte   = writeFire && (byteCnt_q == 3'(NUM_COLS - 1));
    assign qPop       = lastByte;

    // lastMac_q marks the cycle carrying the final mac_en, so no ninth pop.
    assign popFire = (state_q == S_COMPUTE) && !(|bus.a_empty) && !bus.b_empty
                     && !lastMac_q;

    row_queue u_row_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (qFlush),
        .push_i       (qPush),
        .push_entry_i (qPushEntry),
        .pop_i        (qPop),
        .head_o       (qHead),
        .full_o       (qFull),
        .empty_o      (qEmpty)
    );

    // State register, plus a flag that is high only in the first cycle of a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            enteredState_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            enteredState_q <= (state_d != state_q);
        end
    end

    // Phase sequencing: load nine rows, run the compute pops, wait for restart.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rowAccept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lastByte && (rowsLoaded_q == 4'(TOTAL_ROWS - 1))) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (lastMac_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.restart) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Drive FIFO strobes, write byte, MAC controls and status from the phase.
    always_comb begin
        bus.row_ready = !qFull;
        bus.a_wr_en   = '0;
        bus.b_wr_en   = 1'b0;
        bus.wr_data   = '0;
        bus.a_rd_en   = '0;
        bus.b_rd_en   = 1'b0;
        bus.mac_clr   = 1'b0;
        bus.mac_en    = macEn_q;
        bus.load_done = (rowsLoaded_q == 4'(TOTAL_ROWS));
        bus.done      = 1'b0;
        bus.overflow  = overflow_q;

        if ((state_q == S_LOAD) && !qEmpty) begin
            bus.wr_data = rowByte(qHead.data, byteCnt_q);
        end
        if (writeFire) begin
            if (headIsB) begin
                bus.b_wr_en = 1'b1;
            end else begin
                bus.a_wr_en[qHead.idx[2:0]] = 1'b1;
            end
        end
        if (popFire) begin
            bus.a_rd_en = '1;
            bus.b_rd_en = 1'b1;
        end
        if ((state_q == S_COMPUTE) && enteredState_q) begin
            bus.mac_clr = 1'b1;
        end
        if ((state_q == S_DONE) && enteredState_q) begin
            bus.done = 1'b1;
        end
    end

    // Byte/row/pop counters and the MAC strobe pipeline; restart clears the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteCnt_q    <= '0;
            rowsLoaded_q <= '0;
            popCnt_q     <= '0;
            macEn_q      <= 1'b0;
            lastMac_q    <= 1'b0;
        end else begin
            macEn_q   <= popFire;
            lastMac_q <= popFire && (popCnt_q == 3'(NUM_COLS - 1));
            if (qFlush) begin
                byteCnt_q    <= '0;
                rowsLoaded_q <= '0;
                popCnt_q     <= '0;
            end else begin
                if (writeFire) begin
                    byteCnt_q <= byteCnt_q + 3'd1;
                end
                if (lastByte) begin
                    rowsLoaded_q <= rowsLoaded_q + 4'd1;
                end
                if (popFire) begin
                    popCnt_q <= popCnt_q + 3'd1;
                end
            end
        end
    end

    // Sticky overflow: a row offered while the queue was full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (bus.row_valid && qFull) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef LOADER_ORDER_CHECK_EN
    // Expected row index walks 0..8; a mismatching row is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expIdx_q   <= '0;
            orderErr_q <= 1'b0;
        end else begin
            if (qFlush) begin
                expIdx_q <= '0;
            end else if (rowAccept) begin
                expIdx_q <= (expIdx_q == IDX_W'(B_ROW_IDX)) ? '0 : expIdx_q + 4'd1;
            end
            if (bus.row_valid && !qFull && !orderOk) begin
                orderErr_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/fifo_loader.md
# fifo_loader

Sits directly downstream of the memory row fetcher. Accepts 64-bit rows (8 A rows, then vector B), buffers them in a 2-entry row queue, and serializes each row byte-by-byte into the eight per-row A FIFOs or the B FIFO. Once all nine rows are loaded, it sequences the compute phase: it pops every FIFO in lockstep for NUM_COLS cycles and drives the MAC enable and clear signals.

## Interface
- NUM_ROWS, 8, A rows; the B row index equals NUM_ROWS
- NUM_COLS, 8, bytes per row
- DATA_W, 8, element width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- row_data  in  64  row payload; col 0 in [63:56], col 7 in [7:0]
- row_idx  in  4  row number, 0..8
- row_valid  in  1  one-cycle row strobe
- row_ready  out  1  queue can accept a row
- a_wr_en  out  NUM_ROWS  one-hot write enable to the A FIFOs
- b_wr_en  out  1  B FIFO write enable
- wr_data  out  DATA_W  shared FIFO write data
- a_full  in  NUM_ROWS  A FIFO full flags
- b_full  in  1  B FIFO full flag
- a_empty  in  NUM_ROWS  A FIFO empty flags
- b_empty  in  1  B FIFO empty flag
- a_rd_en  out  NUM_ROWS  A FIFO pops
- b_rd_en  out  1  B FIFO pop
- mac_clr  out  1  accumulator clear pulse
- mac_en  out  1  MAC accumulate strobe
- load_done  out  1  level; all 9 rows written
- done  out  1  one-cycle pulse when compute finishes
- restart  in  1  DONE→IDLE request
- overflow  out  1  sticky; row_valid arrived while row_ready was 0

## Operation
- States: IDLE, LOAD, COMPUTE, DONE.
- IDLE→LOAD when the first row is accepted.
- Row queue: 2 entries of {row_idx, row_data}.
  - row_ready = queue not full.
  - row_valid while the queue is full drops the row and sets overflow.
- LOAD:
  - Pops the queue head and writes bytes col 0..7 in order.
  - Target is A FIFO row_idx for rows 0..7, B FIFO for row 8.
  - A write occurs only when the target is not full; while full, hold the byte and counter.
  - byte_cnt is 3 bits and wraps 7→0 on the row's last write, which frees the queue head.
  - rows_loaded counts 0..9; load_done=1 once it reaches 9.
- LOAD→COMPUTE the cycle after the 9th row's last byte is written.
- COMPUTE:
  - mac_clr pulses in the first COMPUTE cycle.
  - A pop is issued (all a_rd_en plus b_rd_en) only when no FIFO is empty; otherwise stall.
  - pop_cnt runs 0..NUM_COLS-1; mac_en is asserted exactly one cycle after each pop.
- COMPUTE→DONE the cycle after the final mac_en; done pulses in that first DONE cycle.
- DONE→IDLE on restart.
  - Clears rows_loaded, load_done and the queue.
  - overflow is cleared only by reset.
- Rows arriving in COMPUTE or DONE are accepted into the queue if there is room; writing resumes only in the next LOAD.

## Timing
- Reset values: every output is 0 except row_ready, which is 1.
- row accept to first wr_en: 1 cycle if the queue was empty (registered queue read).
- Unstalled row: 8 consecutive wr_en cycles.
- Unstalled compute: NUM_COLS pop cycles, last mac_en one cycle later, then done.
- An accept and a head-free in the same cycle are legal; occupancy is unchanged.
- Reset mid-operation: immediate return to IDLE, queue emptied, no partial writes completed.

## Configuration
- LOADER_ORDER_CHECK_EN defined:
  - row_idx must equal the expected next row (0..8 in sequence).
  - A mismatched row is dropped and sets sticky output order_err.
  - The port exists only under the macro.
- Undefined: row_idx is used directly as the destination with no check, and port order_err is absent.

## Structure
- Package loader_pkg: state_t enum, NUM_ROWS, NUM_COLS, B_ROW_IDX=8, ROW_W=64.
- Sub-module row_queue: 2-entry synchronous FIFO with registered head, full/empty outputs.

## Test plan
- Rows 0..8, each byte = 8*row+col, spaced 4 cycles apart → A FIFO r receives 8r..8r+7 in order; B FIFO receives 64..71; load_done=1.
- a_full[3] held high for 5 cycles mid-row 3 → wr_data and byte_cnt hold; row 3 completes with no byte lost or duplicated.
- Three back-to-back row_valid pulses with the queue stalled → third row dropped, overflow=1, row_ready=0 during the third pulse.
- Compute after full load with b_empty forced high for 2 cycles → pops pause, 8 pops total, mac_clr once, 8 mac_en, done one cycle after the last mac_en.
- rst_n asserted during LOAD at row 5 byte 3 → all outputs at reset values; a fresh sequence then loads correctly.
- With LOADER_ORDER_CHECK_EN: send row_idx sequence 0,1,3 → row 3 dropped, order_err=1.
